// File: rtl/bldc_motion_sequencer.sv
// bldc_motion_sequencer: run-state controller in front of the ESC speed/PWM
// datapath. Sequences align, ramp-up, run, ramp-down, direction reversal and
// (optionally) stall fault, and drives pwm_en plus the encoded period_reference.
// Optional feature macro: STALL_DETECT_EN (encoder stall counter -> FAULT).
//
// state     | code | meaning
// ----------+------+-----------------------------------------------------
// IDLE      | 0    | motor off, waiting for a start request
// ALIGN     | 1    | rotor alignment at magnitude 1 for ALIGN_CYCLES
// RAMP_UP   | 2    | +1 magnitude every RAMP_STEP_CYCLES toward target
// RUN       | 3    | holding magnitude
// RAMP_DOWN | 4    | -1 magnitude every RAMP_STEP_CYCLES toward goal
// FAULT     | 5    | stall detected, outputs off until cleared
module bldc_motion_sequencer #(
  parameter int ALIGN_CYCLES     = 256,
  parameter int RAMP_STEP_CYCLES = 1024,
  parameter int STALL_TIMEOUT    = 65535,
  parameter int TMR_WIDTH        = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       dir_req,
  input  logic [6:0] target_mag,
  input  logic       encoder_a,
  input  logic       fault_clr,
  output logic       pwm_en,
  output logic [7:0] period_reference,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ALIGN     = 3'd1;
  localparam logic [2:0] S_RAMP_UP   = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_RAMP_DOWN = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  localparam logic [TMR_WIDTH-1:0] ALIGN_TC = TMR_WIDTH'(ALIGN_CYCLES - 1);
  localparam logic [TMR_WIDTH-1:0] STEP_TC  = TMR_WIDTH'(RAMP_STEP_CYCLES - 1);

  logic [6:0]           mag, mag_nx, goal;
  logic                 dir, dir_nx, goal_zero, motor_on_nx;
  logic [TMR_WIDTH-1:0] tmr, tmr_nx;
  logic [2:0]           state_nx;

`ifdef STALL_DETECT_EN
  localparam logic [TMR_WIDTH-1:0] STALL_TC = TMR_WIDTH'(STALL_TIMEOUT - 1);

  logic                 enc_s1, enc_s2, enc_d, enc_rise, stall_active, stall_hit;
  logic [TMR_WIDTH-1:0] stall_cnt;

  assign enc_rise     = enc_s2 & ~enc_d;
  assign stall_active = (state == S_RAMP_UP) || (state == S_RUN);
  assign stall_hit    = stall_active && !enc_rise && (stall_cnt == STALL_TC);

  // Synchronize encoder_a and register the previous value for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_s1 <= 1'b0;
      enc_s2 <= 1'b0;
      enc_d  <= 1'b0;
    end else begin
      enc_s1 <= encoder_a;
      enc_s2 <= enc_s1;
      enc_d  <= enc_s2;
    end
  end

  // Count cycles since the last encoder rising edge while the motor should be turning.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            stall_cnt <= '0;
    else if (state_nx != state)              stall_cnt <= '0;
    else if (!stall_active || enc_rise)      stall_cnt <= '0;
    else                                     stall_cnt <= stall_cnt + TMR_WIDTH'(1);
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{encoder_a, fault_clr};
`endif

  // Next-state, magnitude, direction and step-timer decode.
  always_comb begin
    state_nx  = state;
    mag_nx    = mag;
    dir_nx    = dir;
    tmr_nx    = tmr + TMR_WIDTH'(1);
    goal_zero = stop || !start || (dir_req != dir);
    goal      = goal_zero ? 7'd0 : target_mag;
    case (state)
      S_IDLE: begin
        mag_nx = 7'd0;
        if (start && !stop && target_mag != 7'd0) begin
          state_nx = S_ALIGN;
          mag_nx   = 7'd1;
          dir_nx   = dir_req;
        end
      end
      S_ALIGN: begin
        mag_nx = 7'd1;
        if (goal_zero)            state_nx = S_RAMP_DOWN;
        else if (tmr == ALIGN_TC) state_nx = (target_mag == 7'd1) ? S_RUN : S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (goal_zero || target_mag < mag) state_nx = S_RAMP_DOWN;
        else if (target_mag == mag)        state_nx = S_RUN;
        else if (tmr == STEP_TC) begin
          mag_nx = mag + 7'd1;
          tmr_nx = '0;
        end
      end
      S_RUN: begin
        tmr_nx = '0;
        if (goal_zero || target_mag < mag) state_nx = S_RAMP_DOWN;
        else if (target_mag > mag)         state_nx = S_RAMP_UP;
      end
      S_RAMP_DOWN: begin
        if (mag == 7'd0) begin
          // Reversal: restart in the new direction only once fully stopped.
          if (start && !stop && dir_req != dir && target_mag != 7'd0) begin
            state_nx = S_ALIGN;
            mag_nx   = 7'd1;
            dir_nx   = dir_req;
          end else begin
            state_nx = S_IDLE;
          end
        end else if (mag == goal) begin
          state_nx = S_RUN;
        end else if (goal > mag) begin
          state_nx = S_RAMP_UP;
        end else if (tmr == STEP_TC) begin
          mag_nx = mag - 7'd1;
          tmr_nx = '0;
        end
      end
      S_FAULT: begin
        mag_nx = 7'd0;
`ifdef STALL_DETECT_EN
        if (fault_clr && !start) state_nx = S_IDLE;
`else
        state_nx = S_IDLE;
`endif
      end
      default: begin
        state_nx = S_IDLE;
        mag_nx   = 7'd0;
      end
    endcase
    if (state_nx != state) tmr_nx = '0;
`ifdef STALL_DETECT_EN
    if (stall_hit) begin
      state_nx = S_FAULT;
      mag_nx   = 7'd0;
      dir_nx   = dir;
      tmr_nx   = '0;
    end
`endif
  end

  assign motor_on_nx = (state_nx == S_ALIGN) || (state_nx == S_RAMP_UP) ||
                       (state_nx == S_RUN)   || (state_nx == S_RAMP_DOWN);

  // Core state registers and outputs, all registered from the next-state decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      mag              <= 7'd0;
      dir              <= 1'b0;
      tmr              <= '0;
      pwm_en           <= 1'b0;
      period_reference <= 8'd0;
      busy             <= 1'b0;
      fault            <= 1'b0;
    end else begin
      state            <= state_nx;
      mag              <= mag_nx;
      dir              <= dir_nx;
      tmr              <= tmr_nx;
      pwm_en           <= motor_on_nx;
      period_reference <= (mag_nx == 7'd0) ? 8'd0 : {dir_nx, mag_nx};
      busy             <= motor_on_nx;
      fault            <= (state_nx == S_FAULT);
    end
  end

endmodule

// File: tb/tb_bldc_motion_sequencer.sv
// Directed bench for bldc_motion_sequencer with short timing parameters
// (ALIGN 8, step 4, stall 64) and encoder_a toggling every 10 clocks.
module tb_bldc_motion_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, start, stop, dir_req, encoder_a, fault_clr;
  logic [6:0] target_mag;
  logic       pwm_en, busy, fault;
  logic [7:0] period_reference;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;
  bit enc_run  = 1'b1;

  bldc_motion_sequencer #(
    .ALIGN_CYCLES(8), .RAMP_STEP_CYCLES(4), .STALL_TIMEOUT(64), .TMR_WIDTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .dir_req(dir_req),
    .target_mag(target_mag), .encoder_a(encoder_a), .fault_clr(fault_clr),
    .pwm_en(pwm_en), .period_reference(period_reference), .busy(busy),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    encoder_a = 1'b0;
    forever begin
      repeat (10) @(negedge clk);
      if (enc_run) encoder_a = ~encoder_a;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic wait_state(input logic [2:0] code, input int budget, output int cycles);
    cycles = 0;
    while (state !== code && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic wait_pr(input logic [7:0] val, input int budget);
    int n = 0;
    while (period_reference !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; dir_req = 1'b0;
    target_mag = 7'd0; fault_clr = 1'b0;
    #1;
    checks++;
    if ({state, pwm_en, period_reference, busy, fault} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got st=%0d pwm=%0d pr=%0d busy=%0d flt=%0d exp all 0",
               state, pwm_en, period_reference, busy, fault);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    start = 1'b1; target_mag = 7'd0;
    repeat (5) @(negedge clk);
    checks++;
    if (state !== 3'd0 || pwm_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_target0 got st=%0d pwm=%0d exp 0/0", state, pwm_en);
    end
    stop = 1'b1; target_mag = 7'd5;
    repeat (5) @(negedge clk);
    checks++;
    if (state !== 3'd0 || period_reference !== 8'd0) begin
      failures++;
      $display("FAIL idle_stop_and_start got st=%0d pr=%0d exp 0/0", state, period_reference);
    end
    start = 1'b0; stop = 1'b0; target_mag = 7'd0;
    @(negedge clk);
  endtask

  task automatic test_start_fwd;
    int n;
    start = 1'b1; dir_req = 1'b0; target_mag = 7'd20;
    @(negedge clk);
    checks++;
    if (state !== 3'd1 || period_reference !== 8'd1 || pwm_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL align_entry got st=%0d pr=%0d pwm=%0d busy=%0d exp 1/1/1/1",
               state, period_reference, pwm_en, busy);
    end
    n = 0;
    while (state === 3'd1 && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL align_length got %0d cycles exp 8", n);
    end
    checks++;
    if (state !== 3'd2 || period_reference !== 8'd1) begin
      failures++;
      $display("FAIL ramp_up_entry got st=%0d pr=%0d exp 2/1", state, period_reference);
    end
    n = 0;
    while (state === 3'd2 && period_reference === 8'd1 && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (n !== 4 || period_reference !== 8'd2) begin
      failures++;
      $display("FAIL first_step got %0d cycles pr=%0d exp 4 cycles pr=2", n, period_reference);
    end
    n = 0;
    while (state === 3'd2 && n < 200) begin n++; @(negedge clk); end
    checks++;
    if (n !== 73) begin
      failures++;
      $display("FAIL ramp_up_length got %0d cycles exp 73", n);
    end
    checks++;
    if (state !== 3'd3 || period_reference !== 8'd20 || busy !== 1'b1) begin
      failures++;
      $display("FAIL run_at_20 got st=%0d pr=%0d busy=%0d exp 3/20/1", state, period_reference, busy);
    end
  endtask

  task automatic test_stop_from_run;
    logic [7:0] exp_pr;
    stop = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 80; k++) begin
      exp_pr = 8'(20 - k / 4);
      checks++;
      if (state !== 3'd4 || period_reference !== exp_pr) begin
        failures++;
        $display("FAIL ramp_down_k%0d got st=%0d pr=%0d exp 4/%0d", k, state, period_reference, exp_pr);
      end
      @(negedge clk);
    end
    checks++;
    if (state !== 3'd0 || pwm_en !== 1'b0 || period_reference !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_idle got st=%0d pwm=%0d pr=%0d busy=%0d exp 0/0/0/0",
               state, pwm_en, period_reference, busy);
    end
    stop = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reversal;
    int n;
    bit dir_flip;
    start = 1'b1; dir_req = 1'b0; target_mag = 7'd10;
    wait_state(3'd3, 200, n);
    checks++;
    if (state !== 3'd3 || period_reference !== 8'd10) begin
      failures++;
      $display("FAIL rev_run_fwd got st=%0d pr=%0d exp 3/10", state, period_reference);
    end
    dir_req = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd4 || period_reference !== 8'd10) begin
      failures++;
      $display("FAIL rev_ramp_down got st=%0d pr=%0d exp 4/10", state, period_reference);
    end
    dir_flip = 1'b0; n = 0;
    while (state === 3'd4 && n < 100) begin
      if (period_reference[7]) dir_flip = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (dir_flip !== 1'b0) begin
      failures++;
      $display("FAIL rev_dir_during_ramp got flip=%0d exp 0", dir_flip);
    end
    checks++;
    if (state !== 3'd1 || period_reference !== 8'h81) begin
      failures++;
      $display("FAIL rev_align got st=%0d pr=%0h exp 1/81", state, period_reference);
    end
    wait_state(3'd3, 200, n);
    checks++;
    if (state !== 3'd3 || period_reference !== 8'h8A) begin
      failures++;
      $display("FAIL rev_run got st=%0d pr=%0h exp 3/8a", state, period_reference);
    end
    stop = 1'b1;
    wait_state(3'd0, 200, n);
    checks++;
    if (state !== 3'd0 || period_reference !== 8'd0) begin
      failures++;
      $display("FAIL rev_stop got st=%0d pr=%0d exp 0/0", state, period_reference);
    end
    stop = 1'b0; start = 1'b0; dir_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_target_change;
    int n;
    start = 1'b1; dir_req = 1'b0; target_mag = 7'd30;
    wait_pr(8'd15, 300);
    checks++;
    if (state !== 3'd2 || period_reference !== 8'd15) begin
      failures++;
      $display("FAIL tc_ramp_at_15 got st=%0d pr=%0d exp 2/15", state, period_reference);
    end
    target_mag = 7'd12;
    @(negedge clk);
    checks++;
    if (state !== 3'd4) begin
      failures++;
      $display("FAIL tc_to_ramp_down got st=%0d exp 4", state);
    end
    wait_state(3'd3, 100, n);
    checks++;
    if (state !== 3'd3 || period_reference !== 8'd12) begin
      failures++;
      $display("FAIL tc_run_at_12 got st=%0d pr=%0d exp 3/12", state, period_reference);
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd4) begin
      failures++;
      $display("FAIL tc_start_drop got st=%0d exp 4", state);
    end
    wait_state(3'd0, 200, n);
    checks++;
    if (state !== 3'd0 || pwm_en !== 1'b0) begin
      failures++;
      $display("FAIL tc_idle got st=%0d pwm=%0d exp 0/0", state, pwm_en);
    end
    target_mag = 7'd0;
    @(negedge clk);
  endtask

  task automatic test_stall;
    int n;
    start = 1'b1; dir_req = 1'b0; target_mag = 7'd5;
    wait_state(3'd3, 200, n);
    checks++;
    if (state !== 3'd3 || period_reference !== 8'd5) begin
      failures++;
      $display("FAIL stall_run got st=%0d pr=%0d exp 3/5", state, period_reference);
    end
    enc_run = 1'b0;
`ifdef STALL_DETECT_EN
    wait_state(3'd5, 200, n);
    checks++;
    if (state !== 3'd5 || fault !== 1'b1 || pwm_en !== 1'b0 || period_reference !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_fault got st=%0d flt=%0d pwm=%0d pr=%0d busy=%0d exp 5/1/0/0/0",
               state, fault, pwm_en, period_reference, busy);
    end
    checks++;
    if (n < 40 || n > 72) begin
      failures++;
      $display("FAIL stall_latency got %0d cycles exp 40..72", n);
    end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 3'd5 || fault !== 1'b1) begin
      failures++;
      $display("FAIL clr_with_start got st=%0d flt=%0d exp 5/1", state, fault);
    end
    start = 1'b0;
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    checks++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL clr_idle got st=%0d flt=%0d exp 0/0", state, fault);
    end
`else
    repeat (150) @(negedge clk);
    checks++;
    if (state !== 3'd3 || fault !== 1'b0 || period_reference !== 8'd5) begin
      failures++;
      $display("FAIL no_stall got st=%0d flt=%0d pr=%0d exp 3/0/5", state, fault, period_reference);
    end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || fault !== 1'b0) begin
      failures++;
      $display("FAIL clr_ignored got st=%0d flt=%0d exp 3/0", state, fault);
    end
    start = 1'b0;
    wait_state(3'd0, 200, n);
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL no_stall_idle got st=%0d exp 0", state);
    end
`endif
    enc_run = 1'b1;
    target_mag = 7'd0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int n;
    start = 1'b1; dir_req = 1'b0; target_mag = 7'd40;
    wait_state(3'd3, 400, n);
    checks++;
    if (state !== 3'd3 || period_reference !== 8'd40) begin
      failures++;
      $display("FAIL pre_reset_run got st=%0d pr=%0d exp 3/40", state, period_reference);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({state, pwm_en, period_reference, busy, fault} !== 14'd0) begin
      failures++;
      $display("FAIL async_reset got st=%0d pwm=%0d pr=%0d busy=%0d flt=%0d exp all 0",
               state, pwm_en, period_reference, busy, fault);
    end
    start = 1'b0; target_mag = 7'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd0 || pwm_en !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got st=%0d pwm=%0d exp 0/0", state, pwm_en);
    end
  endtask

  initial begin
    test_reset();
    test_start_fwd();
    test_stop_from_run();
    test_reversal();
    test_target_change();
    test_stall();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
